// File: rtl/image_loader.sv
// image_loader: frame assembler for the MNIST accelerator front end.
// Pixel beats arrive over a valid/ready bus and are packed row-major into
// image_data. Once a frame is complete it is held with image_valid until the
// classifier core acknowledges it, then the next frame may start.
// Optional build macro IMAGE_LOADER_SOF_CHECK_EN enables start-of-frame
// resynchronisation via in_sof and the frame_err pulse; without it in_sof is
// ignored and frame_err is tied low.
module image_loader #(
    parameter int IMG_W = 14,
    parameter int IMG_H = 14,
    parameter int BUS_W = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_W-1:0]         data_in,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic                     in_ready,
    output logic [IMG_W*IMG_H-1:0]   image_data,
    output logic                     image_valid,
    input  logic                     image_ack,
    output logic [7:0]               frame_count,
    output logic                     frame_err
);

    // Row geometry: a row is split into BPR equal beats.
    localparam int BPR    = IMG_W / BUS_W;
    localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPR - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);

    // Two-state controller: FILL collects beats, HOLD presents the frame.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // A row must be an exact number of beats, otherwise pixels would straddle
    // row boundaries and the packing would be ambiguous.
    generate
        if ((IMG_W % BUS_W) != 0 || BPR < 1) begin : g_bad_geometry
            $error("image_loader: IMG_W must be a non-zero multiple of BUS_W");
        end
    endgenerate

    logic [0:0]        state;
    logic [0:0]        next_state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [BEAT_W-1:0] beat_pos;
    logic [ROW_W-1:0]  row_pos;
    logic [BEAT_W-1:0] beat_nxt;
    logic [ROW_W-1:0]  row_nxt;
    logic              accept;
    logic              sof_restart;
    logic              last_beat;

    assign accept = in_valid && in_ready;

`ifdef IMAGE_LOADER_SOF_CHECK_EN
    logic mid_frame_sof;

    // An accepted SOF beat always lands at row 0, beat 0.
    assign sof_restart   = accept && in_sof;
    assign mid_frame_sof = sof_restart && ((beat_cnt != '0) || (row_cnt != '0));

    // Flag an SOF that arrived while a frame was partly assembled.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= mid_frame_sof;
        end
    end
`else
    logic unused_sof;

    assign sof_restart = 1'b0;
    assign unused_sof  = in_sof;
    assign frame_err   = 1'b0;
`endif

    // Effective write position of the current beat and the position after it.
    always_comb begin
        beat_pos  = sof_restart ? '0 : beat_cnt;
        row_pos   = sof_restart ? '0 : row_cnt;
        last_beat = accept && (row_pos == ROW_LAST) && (beat_pos == BEAT_LAST);
        beat_nxt  = beat_pos + BEAT_W'(1);
        row_nxt   = row_pos;
        if (last_beat) begin
            beat_nxt = '0;
            row_nxt  = '0;
        end else if (beat_pos == BEAT_LAST) begin
            beat_nxt = '0;
            row_nxt  = row_pos + ROW_W'(1);
        end
    end

    // Beat and row position advance only on accepted beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else if (accept) begin
            beat_cnt <= beat_nxt;
            row_cnt  <= row_nxt;
        end
    end

    // FILL goes to HOLD on the final beat; HOLD returns to FILL on acknowledge.
    always_comb begin
        next_state = state;
        case (state)
            ST_FILL: if (last_beat) next_state = ST_HOLD;
            ST_HOLD: if (image_ack) next_state = ST_FILL;
            default: next_state = ST_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    assign image_valid = (state == ST_HOLD);

    // in_ready is registered so it stays low during reset and for the hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (next_state == ST_FILL);
        end
    end

    // Count completed frames; the 8-bit counter wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (last_beat) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    // Write each accepted beat into its slice; the frame is never cleared
    // between frames because the next frame overwrites every bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            image_data <= '0;
        end else begin
            for (int r = 0; r < IMG_H; r++) begin
                for (int k = 0; k < BPR; k++) begin
                    if (accept && (row_pos == ROW_W'(r)) && (beat_pos == BEAT_W'(k))) begin
                        image_data[r*IMG_W + k*BUS_W +: BUS_W] <= data_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: self-checking bench for image_loader. A flat-index frame
// model predicts every output after every clock edge; directed steps cover
// reset, hold/ack, streaming period, SOF handling and a small geometry.
module tb_image_loader;

    localparam int IMG_W = 14;
    localparam int IMG_H = 14;
    localparam int BUS_W = 7;
    localparam int NBITS = IMG_W * IMG_H;
    localparam int NBEATS = NBITS / BUS_W;

`ifdef IMAGE_LOADER_SOF_CHECK_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [BUS_W-1:0] data_in;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [NBITS-1:0] image_data;
    logic             image_valid;
    logic             image_ack;
    logic [7:0]       frame_count;
    logic             frame_err;

    logic        s_reset;
    logic [3:0]  s_data;
    logic        s_valid;
    logic        s_sof;
    logic        s_ready;
    logic [31:0] s_image;
    logic        s_ivalid;
    logic        s_ack;
    logic [7:0]  s_count;
    logic        s_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit               m_ready;
    bit               m_hold;
    bit               m_err;
    int               m_idx;
    int               m_count;
    logic [NBITS-1:0] m_img;

    always #5 clk = ~clk;

    image_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BUS_W(BUS_W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .image_data(image_data),
        .image_valid(image_valid), .image_ack(image_ack),
        .frame_count(frame_count), .frame_err(frame_err)
    );

    image_loader #(.IMG_W(8), .IMG_H(4), .BUS_W(4)) dut_small (
        .clk(clk), .reset(s_reset), .data_in(s_data), .in_valid(s_valid),
        .in_sof(s_sof), .in_ready(s_ready), .image_data(s_image),
        .image_valid(s_ivalid), .image_ack(s_ack),
        .frame_count(s_count), .frame_err(s_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the frame is a flat sequence of beats, beat i at bits [i*BUS_W +: BUS_W].
    task automatic modelEdge();
        int p;
        if (reset) begin
            m_img = '0; m_hold = 0; m_ready = 0; m_count = 0; m_err = 0; m_idx = 0;
        end else begin
            m_err = 0;
            if (in_valid && m_ready) begin
                p = m_idx;
                if (SOF_EN && in_sof) begin
                    if (p != 0) m_err = 1;
                    p = 0;
                end
                m_img[p*BUS_W +: BUS_W] = data_in;
                p++;
                if (p == NBEATS) begin
                    p = 0;
                    m_count = (m_count + 1) % 256;
                    m_hold = 1;
                end
                m_idx = p;
            end else if (m_hold && image_ack) begin
                m_hold = 0;
            end
            m_ready = !m_hold;
        end
    endtask

    task automatic checkOutput();
        check("in_ready", in_ready, m_ready);
        check("image_valid", image_valid, m_hold);
        check("image_data", image_data, m_img);
        check("frame_count", frame_count, m_count[7:0]);
        check("frame_err", frame_err, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic v, input logic [BUS_W-1:0] d, input logic s,
                                 input logic a, input logic r);
        in_valid  = v;
        data_in   = d;
        in_sof    = s;
        image_ack = a;
        reset     = r;
        cycle();
    endtask

    initial begin
        logic [NBITS-1:0] exp_img;
        logic [NBITS-1:0] all_ones;
        logic [6:0]       first_data;
        int               rises[$];
        bit               prev_valid;
        int               more;

        reset = 1; in_valid = 0; data_in = '0; in_sof = 0; image_ack = 0;
        s_reset = 1; s_valid = 0; s_data = '0; s_sof = 0; s_ack = 0;

        // Reset state
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_frame_count", frame_count, 8'd0);
        applyStimulus(1, 7'd0, 0, 0, 0);
        check("ready_after_reset", in_ready, 1'b1);

        // One frame of beat j = j, ack low
        exp_img = '0;
        for (int j = 0; j < NBEATS; j++) begin
            applyStimulus(1, 7'(j), 0, 0, 0);
            exp_img[7*j +: 7] = 7'(j);
        end
        check("t1_valid", image_valid, 1'b1);
        check("t1_ready", in_ready, 1'b0);
        check("t1_data", image_data, exp_img);
        check("t1_count", frame_count, 8'd1);

        // Hold with in_valid asserted, then acknowledge
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 7'($urandom), 0, 0, 0);
            check("hold_data", image_data, exp_img);
        end
        applyStimulus(1, 7'h11, 0, 1, 0);
        check("ack_ready", in_ready, 1'b1);
        check("ack_valid", image_valid, 1'b0);

        // Reset after 13 beats, then a full frame of 7F
        for (int j = 0; j < 13; j++) applyStimulus(1, 7'($urandom), 0, 0, 0);
        applyStimulus(1, 7'h7F, 0, 0, 1);
        applyStimulus(1, 7'h7F, 0, 0, 0);
        for (int j = 0; j < NBEATS; j++) applyStimulus(1, 7'h7F, 0, 0, 0);
        all_ones = '1;
        check("abort_data", image_data, all_ones);
        check("abort_count", frame_count, 8'd1);

        // Continuous stream, ack tied high, three frames
        applyStimulus(1, 7'($urandom), 0, 1, 1);
        prev_valid = 0;
        for (int i = 0; i < 200 && rises.size() < 3; i++) begin
            applyStimulus(1, 7'($urandom), 0, 1, 0);
            if (image_valid && !prev_valid) rises.push_back(cyc);
            prev_valid = image_valid;
        end
        check("stream_frames", rises.size(), 3);
        if (rises.size() == 3) begin
            check("stream_period1", rises[1] - rises[0], 29);
            check("stream_period2", rises[2] - rises[1], 29);
        end
        check("stream_count", frame_count, 8'd3);

        // Mid-frame SOF
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0);
        first_data = 7'h2A;
        applyStimulus(1, first_data, 0, 0, 0);
        for (int j = 1; j < 5; j++) applyStimulus(1, 7'($urandom), 0, 0, 0);
        applyStimulus(1, 7'h55, 1, 0, 0);
        check("sof_err_pulse", frame_err, SOF_EN);
        check("sof_low_bits", image_data[6:0], SOF_EN ? 7'h55 : first_data);
        more = SOF_EN ? 27 : 22;
        for (int j = 0; j < more; j++) begin
            applyStimulus(1, 7'($urandom), 0, 0, 0);
            if (j == 0) check("sof_err_one_cycle", frame_err, 1'b0);
        end
        check("sof_complete", image_valid, 1'b1);
        check("sof_count", frame_count, 8'd1);
        applyStimulus(0, '0, 0, 1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 7'($urandom), ($urandom % 16) == 0,
                          ($urandom % 3) == 0, ($urandom % 200) == 0);
        end

        // Small geometry: 8x4 pixels, 4-bit bus
        applyStimulus(0, '0, 0, 0, 0);
        s_reset = 0;
        cycle();
        check("small_ready", s_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            s_valid = 1;
            s_data  = 4'(k + 1);
            cycle();
        end
        s_valid = 0;
        check("small_valid", s_ivalid, 1'b1);
        check("small_data", s_image, 32'h87654321);
        check("small_pixel_3_7", s_image[31], 1'b1);
        check("small_count", s_count, 8'd1);
        check("small_ready_hold", s_ready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_loader.md
# image_loader

Parametrised frame loader for the MNIST accelerator front end. It accepts a monochrome image over a narrow pixel bus with a valid/ready handshake and assembles it row-major into one flat register. It presents the complete frame to the classifier core and holds it until the core acknowledges it. It generalises the fixed 14x14, 7-bit row reader with configurable geometry and bus width, a proper input handshake, frame hold/acknowledge, start-of-frame resynchronisation and a frame counter.

## Interface
Parameters:
- IMG_W, 14, pixels per row.
- IMG_H, 14, rows per frame.
- BUS_W, 7, pixels per input beat. IMG_W % BUS_W must be 0; otherwise elaboration fails.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  BUS_W  pixel beat; bit i is column k*BUS_W+i of the current row, where k is the beat index within the row.
- in_valid  in  1  data_in is valid this cycle.
- in_sof  in  1  start-of-frame marker; qualified by in_valid.
- in_ready  out  1  loader accepts a beat this cycle.
- image_data  out  IMG_W*IMG_H  assembled frame; pixel (r,c) at bit r*IMG_W+c.
- image_valid  out  1  image_data holds a complete frame.
- image_ack  in  1  consumer takes the frame; qualified by image_valid.
- frame_count  out  8  completed frames since reset; wraps 255->0.
- frame_err  out  1  one-cycle pulse on a mid-frame in_sof (see Configuration).

## Operation
- Beats per row is BPR = IMG_W/BUS_W. The block keeps a beat counter (0..BPR-1) and a row counter (0..IMG_H-1).
- States:
  - FILL: in_ready=1.
  - HOLD: in_ready=0 and image_valid=1.
- A beat is accepted when in_valid && in_ready. On acceptance, data_in is written into image_data bits [r*IMG_W+k*BUS_W +: BUS_W]. The beat counter increments; at BPR-1 it clears and the row counter increments.
- Accepting the last beat (row IMG_H-1, beat BPR-1) causes:
  - both counters clear;
  - frame_count increments;
  - the state moves FILL->HOLD.
- HOLD->FILL occurs on image_valid && image_ack. image_data is not cleared; every bit is overwritten by the next frame.
- image_ack while in FILL is ignored. in_valid while in HOLD is not accepted; the source must keep it asserted.
- Reset outputs: image_data=0, image_valid=0, in_ready=0, frame_count=0, frame_err=0. The counters clear and the state is FILL.
- Reset mid-frame discards the partial frame. Reset in HOLD drops the held frame.

## Timing
- in_ready rises 1 cycle after reset deasserts.
- Last beat accepted at edge N: image_valid=1 and final image_data are visible after edge N; in_ready=0 in the same cycle.
- image_data is stable for the whole HOLD interval.
- image_ack sampled at edge M: after M, image_valid=0 and in_ready=1. The earliest next beat is accepted at edge M+1. There is one bubble per frame.
- Minimum frame period is IMG_H*BPR+1 cycles with continuous in_valid and image_ack tied high. The default geometry gives 29 cycles.
- frame_err is asserted for exactly the cycle after the offending beat's edge.

## Configuration
- IMAGE_LOADER_SOF_CHECK_EN defined:
  - An accepted beat with in_sof=1 forces beat/row position 0. That beat is written as row 0, beat 0.
  - If the counters were not both 0 at that point, frame_err pulses and the partial frame is abandoned; frame_count is unchanged.
  - in_sof on a beat already at position 0 is normal.
- Undefined: in_sof is ignored, frame boundaries come purely from the counters, and frame_err is tied 0.

## Test plan
- Reset then 28 beats (default params), beat j = j[6:0] with ack held low -> image_valid rises after the 28th accept edge. Bits [7j+6:7j] = j. in_ready=0 and frame_count=1.
- Holding frame, in_valid high for 10 cycles -> no accepts, image_data unchanged. Pulse image_ack -> next cycle in_ready=1 and image_valid=0.
- Continuous stream with image_ack tied 1 for 3 frames -> frame period 29 cycles, frame_count=3, each frame's data matches its source.
- SOF_CHECK_EN: 5 beats, then a beat with in_sof=1 carrying 7'h55 -> frame_err one-cycle pulse; that beat lands at bits [6:0]. 27 more beats complete the frame and frame_count=1. Without the macro, the same stimulus completes after the 28th total beat and frame_err stays 0.
- Reset asserted after 13 beats, then a full frame of 7'h7F -> all 196 bits = 1, with no residue from the aborted frame.
- Params IMG_W=8, IMG_H=4, BUS_W=4 -> 8 beats per frame, 32-bit image_data, pixel (3,7) at bit 31.
